// File: rtl/dcf77_signal_generator_if.sv
// Bus bundle for the DCF77 generator: the frame offer, its acknowledge and the outgoing time signal.
// The slave modport is the generator side and the master modport is the frame-source side.
interface dcf77_signal_generator_if;
  logic        enable_in;
  logic [58:0] wb_parallel_in;
  logic        load_in;
  logic        load_ack_out;
  logic        sgn_out;
  logic [5:0]  sec_idx_out;
  logic        minute_start_out;
  logic        busy_out;
  logic [1:0]  state_dbg;

  modport slave (
    input  enable_in, wb_parallel_in, load_in,
    output load_ack_out, sgn_out, sec_idx_out, minute_start_out, busy_out, state_dbg
  );

  modport master (
    output enable_in, wb_parallel_in, load_in,
    input  load_ack_out, sgn_out, sec_idx_out, minute_start_out, busy_out, state_dbg
  );
endinterface

// File: rtl/dcf77_signal_generator.sv
// DCF77 minute-frame generator: shapes a 59-bit frame into 100/200 ms carrier-reduction pulses.
// A frame is offered into a shadow register and is picked up at the next minute boundary.
module dcf77_signal_generator #(
  parameter int CLK_DIV = 10000
) (
  input  logic                          clk_in,
  input  logic                          rst_n_in,
  dcf77_signal_generator_if.slave       io_bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PULSE = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;
  localparam logic [1:0] S_MARK  = 2'd3;

  localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);

  logic [1:0]  r_state;
  logic [15:0] r_presc;
  logic [6:0]  r_unit;
  logic [5:0]  r_sec;
  logic [58:0] r_shadow;
  logic [58:0] r_active;
  logic        r_pending;
  logic        r_ack;
  logic        r_sgn;
  logic        r_min_start;

  logic        w_tick;
  logic        w_bit;
  logic        w_unit_last;
  logic        w_pulse_end;
  logic        w_accept;
  logic        w_boundary;
  logic        w_take_shadow;
  logic [5:0]  w_sec_next;
  logic [1:0]  w_next_state;

  assign w_tick      = (r_state != S_IDLE) && (r_presc == DIV_LAST);
  assign w_bit       = (r_sec < 6'd59) ? r_active[r_sec] : 1'b0;
  assign w_unit_last = (r_unit == 7'd99);
  assign w_sec_next  = (r_sec == 6'd59) ? 6'd0 : r_sec + 6'd1;
  assign w_pulse_end = w_tick && (w_bit ? (r_unit == 7'd19) : (r_unit == 7'd9));

  // Offer handshake: load_in is an offer, taken only while no frame is pending;
  // load_ack_out pulses for one cycle in the cycle after an offer is taken.
  assign w_accept      = io_bus.load_in && !r_pending;
  assign w_take_shadow = w_boundary && r_pending;

  always_comb begin
    w_next_state = r_state;
    w_boundary   = 1'b0;
    if (!io_bus.enable_in) begin
      w_next_state = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_pending) begin
            w_next_state = S_PULSE;
            w_boundary   = 1'b1;
          end
        end
        S_PULSE: begin
          if (w_pulse_end) w_next_state = S_GAP;
        end
        S_GAP: begin
          if (w_tick && w_unit_last) w_next_state = (w_sec_next == 6'd59) ? S_MARK : S_PULSE;
        end
        S_MARK: begin
          if (w_tick && w_unit_last) begin
            w_next_state = S_PULSE;
            w_boundary   = 1'b1;
          end
        end
        default: w_next_state = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      r_state     <= S_IDLE;
      r_presc     <= '0;
      r_unit      <= '0;
      r_sec       <= '0;
      r_shadow    <= '0;
      r_active    <= '0;
      r_pending   <= 1'b0;
      r_ack       <= 1'b0;
      r_sgn       <= 1'b0;
      r_min_start <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_sgn       <= (w_next_state == S_PULSE);
      r_min_start <= w_boundary;
      r_ack       <= w_accept;

      // A same-cycle offer only lands in the shadow; the boundary copy sees the old shadow.
      if (w_take_shadow) r_active <= r_shadow;
      if (w_accept) begin
        r_shadow  <= io_bus.wb_parallel_in;
        r_pending <= 1'b1;
      end else if (w_take_shadow) begin
        r_pending <= 1'b0;
      end

      if ((w_next_state == S_IDLE) || (r_state == S_IDLE)) begin
        r_presc <= '0;
        r_unit  <= '0;
        r_sec   <= '0;
      end else begin
        r_presc <= w_tick ? 16'd0 : r_presc + 16'd1;
        if (w_tick) begin
          if (w_unit_last) begin
            r_unit <= '0;
            r_sec  <= w_sec_next;
          end else begin
            r_unit <= r_unit + 7'd1;
          end
        end
      end
    end
  end

  assign io_bus.load_ack_out     = r_ack;
  assign io_bus.sgn_out          = r_sgn;
  assign io_bus.sec_idx_out      = r_sec;
  assign io_bus.minute_start_out = r_min_start;
  assign io_bus.busy_out         = (r_state != S_IDLE);
  assign io_bus.state_dbg        = r_state;

endmodule

// File: tb/tb_dcf77_signal_generator.sv
// Directed bench for dcf77_signal_generator at CLK_DIV=2 (second = 200 cycles, minute = 12000 cycles).
// Expected pulse widths and rise-to-rise gaps are queued when a frame is offered and popped per pulse.
module tb_dcf77_signal_generator;

  logic        clk_in;
  logic        rst_n_in;
  logic [63:0] cyc;
  int          n_checks;
  int          n_errors;

  // Each entry is {rise-to-rise gap in cycles (0 = unchecked), pulse width in cycles}.
  logic [17:0] exp_q[$];
  logic        mon_en;
  logic        mon_in_pulse;
  logic [7:0]  mon_width;
  logic [63:0] mon_rise;
  logic [63:0] mon_last_rise;

  dcf77_signal_generator_if dut_if ();

  dcf77_signal_generator #(
    .CLK_DIV (2)
  ) dut (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .io_bus   (dut_if.slave)
  );

  // Clock and reset
  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  always @(posedge clk_in) begin
    if (!rst_n_in) cyc <= cyc + 64'd1;
    else           cyc <= cyc + 64'd1;
  end

  initial cyc = 64'd0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Scoreboard: measure every sgn_out pulse and compare with the head of exp_q.
  always @(negedge clk_in) begin
    if (!mon_en) begin
      mon_in_pulse = 1'b0;
      mon_width    = 8'd0;
    end else if (dut_if.sgn_out === 1'b1) begin
      if (!mon_in_pulse) begin
        mon_in_pulse = 1'b1;
        mon_width    = 8'd1;
        mon_rise     = cyc;
      end else begin
        mon_width = mon_width + 8'd1;
      end
    end else if (mon_in_pulse) begin
      mon_in_pulse = 1'b0;
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", 64'(mon_width), 64'd0);
      end else begin
        logic [17:0] e;
        e = exp_q.pop_front();
        chk("pulse_width", 64'(mon_width), 64'(e[7:0]));
        if (e[17:8] != 10'd0) chk("pulse_period", mon_rise - mon_last_rise, 64'(e[17:8]));
      end
      mon_last_rise = mon_rise;
    end
  end

  // Driver tasks
  task automatic step(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic push_frame(input logic [58:0] f, input logic first);
    for (int k = 0; k < 59; k++) begin
      logic [9:0] gap;
      logic [7:0] wid;
      gap = (k == 0) ? (first ? 10'd0 : 10'd400) : 10'd200;
      wid = f[k] ? 8'd40 : 8'd20;
      exp_q.push_back({gap, wid});
    end
  endtask

  task automatic load_frame(input logic [58:0] f, output logic [63:0] t_start);
    dut_if.load_in        = 1'b1;
    dut_if.wb_parallel_in = f;
    push_frame(f, 1'b1);
    step(1);
    chk("load_ack", 64'(dut_if.load_ack_out), 64'd1);
    chk("busy_before_start", 64'(dut_if.busy_out), 64'd0);
    dut_if.load_in = 1'b0;
    step(1);
    chk("start_ms", 64'(dut_if.minute_start_out), 64'd1);
    chk("start_sgn", 64'(dut_if.sgn_out), 64'd1);
    chk("start_busy", 64'(dut_if.busy_out), 64'd1);
    chk("start_sec", 64'(dut_if.sec_idx_out), 64'd0);
    chk("ack_one_cycle", 64'(dut_if.load_ack_out), 64'd0);
    t_start = cyc;
  endtask

  task automatic wait_ms(output logic [63:0] t);
    logic found;
    found = 1'b0;
    t     = 64'd0;
    for (int i = 0; i < 13000 && !found; i++) begin
      @(negedge clk_in);
      if (dut_if.minute_start_out === 1'b1) begin
        found = 1'b1;
        t     = cyc;
      end
    end
    chk("minute_start_seen", 64'(found), 64'd1);
  endtask

  initial begin
    logic [63:0] t0, t1, t2, t3, t4, t5, rnd;
    logic [58:0] frame_a, frame_b, frame_c, frame_d, frame_e;

    n_checks      = 0;
    n_errors      = 0;
    mon_en        = 1'b1;
    mon_in_pulse  = 1'b0;
    mon_width     = 8'd0;
    mon_rise      = 64'd0;
    mon_last_rise = 64'd0;
    rst_n_in              = 1'b0;
    dut_if.enable_in      = 1'b0;
    dut_if.load_in        = 1'b0;
    dut_if.wb_parallel_in = '0;

    // Reset state
    step(3);
    chk("rst_sgn", 64'(dut_if.sgn_out), 64'd0);
    chk("rst_ack", 64'(dut_if.load_ack_out), 64'd0);
    chk("rst_ms", 64'(dut_if.minute_start_out), 64'd0);
    chk("rst_busy", 64'(dut_if.busy_out), 64'd0);
    chk("rst_sec", 64'(dut_if.sec_idx_out), 64'd0);
    chk("rst_state", 64'(dut_if.state_dbg), 64'd0);
    rst_n_in = 1'b1;
    step(2);
    dut_if.enable_in = 1'b1;
    step(4);
    chk("idle_without_frame", 64'(dut_if.busy_out), 64'd0);

    // Minute 0: all-zero frame
    frame_a = '0;
    load_frame(frame_a, t0);

    // Offer B mid-minute, then a second offer C that must be refused
    step(3000);
    frame_b = '0;
    frame_b[0]  = 1'b1;
    frame_b[58] = 1'b1;
    dut_if.load_in        = 1'b1;
    dut_if.wb_parallel_in = frame_b;
    push_frame(frame_b, 1'b0);
    step(1);
    chk("offer_b_ack", 64'(dut_if.load_ack_out), 64'd1);
    dut_if.load_in = 1'b0;
    step(100);
    frame_c = {59{1'b1}};
    dut_if.load_in        = 1'b1;
    dut_if.wb_parallel_in = frame_c;
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("offer_c_no_ack", 64'(dut_if.load_ack_out), 64'd0);
    end
    dut_if.load_in = 1'b0;

    // Minute 1: frame B
    wait_ms(t1);
    chk("minute_len_0", t1 - t0, 64'd12000);
    step(6050);
    chk("sec_idx_30", 64'(dut_if.sec_idx_out), 64'd30);
    chk("busy_running", 64'(dut_if.busy_out), 64'd1);

    // Minute 2: B repeats with no new offer
    push_frame(frame_b, 1'b0);
    wait_ms(t2);
    chk("minute_len_1", t2 - t1, 64'd12000);
    step(2005);
    chk("sec10_pulse", 64'(dut_if.sgn_out), 64'd1);
    chk("sec10_idx", 64'(dut_if.sec_idx_out), 64'd10);

    // Drop enable mid-pulse
    mon_en = 1'b0;
    exp_q.delete();
    dut_if.enable_in = 1'b0;
    step(1);
    chk("dis_sgn", 64'(dut_if.sgn_out), 64'd0);
    chk("dis_busy", 64'(dut_if.busy_out), 64'd0);
    chk("dis_sec", 64'(dut_if.sec_idx_out), 64'd0);
    dut_if.enable_in = 1'b1;
    step(500);
    chk("reenable_idle_busy", 64'(dut_if.busy_out), 64'd0);
    chk("reenable_idle_sgn", 64'(dut_if.sgn_out), 64'd0);
    chk("reenable_idle_ms", 64'(dut_if.minute_start_out), 64'd0);

    // Random frame D, then reset during second 30
    mon_en = 1'b1;
    rnd = {$urandom(), $urandom()};
    frame_d = rnd[58:0];
    load_frame(frame_d, t3);
    step(6003);
    chk("sec30_pulse", 64'(dut_if.sgn_out), 64'd1);
    chk("sec30_idx", 64'(dut_if.sec_idx_out), 64'd30);
    mon_en = 1'b0;
    exp_q.delete();
    rst_n_in = 1'b0;
    step(1);
    chk("midrst_sgn", 64'(dut_if.sgn_out), 64'd0);
    chk("midrst_busy", 64'(dut_if.busy_out), 64'd0);
    chk("midrst_sec", 64'(dut_if.sec_idx_out), 64'd0);
    chk("midrst_ms", 64'(dut_if.minute_start_out), 64'd0);
    chk("midrst_ack", 64'(dut_if.load_ack_out), 64'd0);

    // Release reset with an offer in the very first cycle: random frame E for a full minute
    rst_n_in = 1'b1;
    mon_en   = 1'b1;
    rnd = {$urandom(), $urandom()};
    frame_e = rnd[58:0];
    load_frame(frame_e, t4);
    wait_ms(t5);
    chk("minute_len_e", t5 - t4, 64'd12000);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    mon_en = 1'b0;
    step(2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dcf77_signal_generator.md
DCF77_SIGNAL_GENERATOR -- requirements
Module: dcf77_signal_generator

Interface
REQ-001 SHALL have parameter CLK_DIV, default 10000, clk_in cycles per 10 ms time unit (range 2..65535).
REQ-002 SHALL have port clk_in  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n_in  input  1  reset; one clock, synchronous, active-low.
REQ-004 SHALL have port enable_in  input  1  transmission enable.
REQ-005 SHALL have port wb_parallel_in  input  59  minute frame; bit k is transmitted in second k.
REQ-006 SHALL have port load_in  input  1  frame-offer strobe for wb_parallel_in.
REQ-007 SHALL have port load_ack_out  output  1  one-cycle pulse when an offered frame is accepted.
REQ-008 SHALL have port sgn_out  output  1  demodulated DCF77 signal; high = carrier reduced.
REQ-009 SHALL have port sec_idx_out  output  6  current second index, 0..59.
REQ-010 SHALL have port minute_start_out  output  1  one-cycle pulse at the start of each second 0.
REQ-011 SHALL have port busy_out  output  1  high while transmitting (state != IDLE).

Function
REQ-012 SHALL run a prescaler 0..CLK_DIV-1; tick = prescaler at CLK_DIV-1; the prescaler wraps to 0 on tick and is held at 0 in IDLE.
REQ-013 SHALL run a unit counter 0..99 and a second counter 0..59, both advancing only on tick; unit wraps 99->0 and increments second; second wraps 59->0.
REQ-014 SHALL hold a 59-bit shadow register and a pending flag; load_in with pending=0 copies wb_parallel_in into shadow, sets pending, and pulses load_ack_out in the next cycle.
REQ-015 SHALL ignore load_in while pending=1 (no ack, shadow unchanged).
REQ-016 SHALL, at each minute boundary, copy shadow into the active frame and clear pending if pending=1, otherwise retransmit the previous active frame unchanged.
REQ-017 SHALL have FSM states IDLE, PULSE, GAP, MARK.
REQ-018 IDLE -> PULSE when enable_in=1 and pending=1 (a frame has been offered); that cycle performs the REQ-016 copy, zeroes all counters and pulses minute_start_out next cycle.
REQ-019 PULSE -> GAP on the tick that ends unit 9 when the active bit is 0, or on the tick that ends unit 19 when it is 1.
REQ-020 GAP -> PULSE on the tick ending unit 99 when the next second is 0..58; GAP -> MARK on that tick when the next second is 59.
REQ-021 MARK -> PULSE on the tick ending unit 99 of second 59 (minute boundary, REQ-016 applied, minute_start_out pulsed).
REQ-022 Any state -> IDLE when enable_in=0, taking effect in the next cycle; counters cleared; pending and shadow retained.
REQ-023 sgn_out SHALL be registered and high exactly while state=PULSE: 10 units (10*CLK_DIV cycles) for a 0, 20 units for a 1, and no pulse in second 59.
REQ-024 sgn_out rising edges SHALL be exactly 100*CLK_DIV cycles apart within seconds 0..58, with a 200*CLK_DIV-cycle gap across second 59.
REQ-025 sec_idx_out SHALL equal the second counter; it reads 0 in IDLE.
REQ-026 A load_in accepted in the same cycle as a minute boundary SHALL reach the shadow only; the boundary copy uses the pre-load shadow contents.

Reset
REQ-027 rst_n_in=0 at a clock edge SHALL force state IDLE, all counters 0, pending 0, shadow and active frame 0, sgn_out 0, load_ack_out 0, minute_start_out 0, busy_out 0.
REQ-028 Reset asserted mid-pulse SHALL drop sgn_out in the cycle after the reset edge; the first frame after reset requires a new load_in.

Verification (CLK_DIV=2: unit=2 cycles, second=200 cycles)
REQ-029 Reset, enable_in=1, load frame 59'h0 -> ack 1 cycle later; 59 pulses of 20 cycles each, 200-cycle period, 400-cycle silence, minute_start_out every 12000 cycles.
REQ-030 Frame with only bit 0 and bit 58 set -> 40-cycle pulses in seconds 0 and 58; 20-cycle pulses in all other seconds 1..57; none in second 59.
REQ-031 Offer frame B during minute N while frame A is active -> ack once; A completes; B starts at the next minute_start_out; a second offer before that boundary gets no ack.
REQ-032 No new offer across a boundary -> identical pulse pattern repeats; pending stays 0.
REQ-033 Drop enable_in mid-PULSE -> sgn_out=0, busy_out=0 and sec_idx_out=0 next cycle; re-enable with pending=0 -> remains IDLE until load_in.
REQ-034 Assert rst_n_in during second 30 -> all outputs 0 the next cycle; load_in accepted (ack pulsed) on the first cycle after release.
